// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant.
// Owner keeps the grant while requesting, up to MAX_HOLD cycles.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    localparam int CW = (MAX_HOLD > 15) ? $clog2(MAX_HOLD + 1) : 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [2:0]      owner;
    logic [2:0]      owner_nx;
    logic [2:0]      ptr;
    logic [2:0]      ptr_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic [7:0]      cand;
    logic [2:0]      win;
    logic            win_any;
    logic            hold_done;
    logic            new_grant;
    logic [7:0]      gnt_nx;
    logic [2:0]      idx_nx;
    logic            valid_nx;

    // Owner has used up its slot once the counter reaches MAX_HOLD-1.
    assign hold_done = (MAX_HOLD != 0) && (cnt >= CW'(MAX_HOLD - 1));

    // Round-robin search from ptr; the current owner is never a candidate.
    always_comb begin
        cand = req;
        if (state == GRANT) begin
            cand[owner] = 1'b0;
        end
        win     = 3'd0;
        win_any = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (cand[ptr + 3'(i)]) begin
                win     = ptr + 3'(i);
                win_any = 1'b1;
            end
        end
    end

    // Next-state logic: hold, release, timeout handoff or go idle.
    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        ptr_nx    = ptr;
        cnt_nx    = cnt;
        new_grant = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_any) begin
                    new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    if (win_any) begin
                        new_grant = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end else if (hold_done && win_any) begin
                    new_grant = 1'b1;
                end else if (cnt != CW'(MAX_HOLD)) begin
                    cnt_nx = cnt + 1'b1;
                end
            end
        endcase
        if (new_grant) begin
            state_nx = GRANT;
            owner_nx = win;
            ptr_nx   = win + 3'd1;
            cnt_nx   = '0;
        end
    end

    // Output decode of the next owner, registered below.
    always_comb begin
        gnt_nx   = 8'h00;
        idx_nx   = 3'd0;
        valid_nx = 1'b0;
        if (state_nx == GRANT) begin
            gnt_nx   = 8'd1 << owner_nx;
            idx_nx   = owner_nx;
            valid_nx = 1'b1;
        end
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 3'd0;
            ptr       <= 3'd0;
            cnt       <= '0;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            ptr       <= ptr_nx;
            cnt       <= cnt_nx;
            gnt       <= gnt_nx;
            gnt_idx   <= idx_nx;
            gnt_valid <= valid_nx;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Testbench for rr_arbiter_8: directed scenarios plus random
// requests compared against a cycle-level reference model.
module tb_rr_arbiter_8;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int errors = 0;
    int checks = 0;

    // Reference model: owner index (-1 = none), search start, cycles owned.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_owned = 0;

    rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int skip);
        for (int i = 0; i < 8; i++) begin
            int k;
            k = (m_ptr + i) % 8;
            if (r[k] && k != skip) return k;
        end
        return -1;
    endfunction

    function automatic logic [2:0] encode(input logic [7:0] g);
        logic [2:0] e;
        e = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (g[i]) e = 3'(i);
        end
        return e;
    endfunction

    task automatic model_grant(input int k);
        m_owner = k;
        m_ptr   = (k + 1) % 8;
        m_owned = 1;
    endtask

    task automatic model_edge(input logic [7:0] r);
        int k;
        if (m_owner < 0) begin
            k = pick(r, -1);
            if (k >= 0) model_grant(k);
        end else begin
            k = pick(r, m_owner);
            if (!r[m_owner]) begin
                if (k >= 0) model_grant(k);
                else m_owner = -1;
            end else if (MH != 0 && m_owned >= MH && k >= 0) begin
                model_grant(k);
            end else begin
                m_owned++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] eg;
        eg = (m_owner < 0) ? 8'h00 : (8'd1 << m_owner);
        chk({tag, ":gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ":idx"}, 32'(gnt_idx),
            32'((m_owner < 0) ? 0 : m_owner));
        chk({tag, ":valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
        chk({tag, ":onehot0"}, 32'($onehot0(gnt)), 32'd1);
        chk({tag, ":valid_or"}, 32'(gnt_valid), 32'(|gnt));
        chk({tag, ":idx_enc"}, 32'(gnt_idx), 32'(encode(gnt)));
    endtask

    task automatic step(input string tag, input logic [7:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        req   = 8'h00;
        rst_n = 1'b0;
        #1;
        m_owner = -1;
        m_ptr   = 0;
        m_owned = 0;
        chk("rst:gnt", 32'(gnt), 32'h0);
        chk("rst:idx", 32'(gnt_idx), 32'h0);
        chk("rst:valid", 32'(gnt_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold:gnt", 32'(gnt), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] r;

        // Reset state.
        do_reset();

        // Single request and release.
        step("single", 8'h10);
        chk("single:idx4", 32'(gnt_idx), 32'd4);
        chk("single:gnt", 32'(gnt), 32'h10);
        step("single_rel", 8'h00);
        chk("single_rel:gnt", 32'(gnt), 32'h0);

        // Fairness: all request, each owner drops once granted.
        do_reset();
        step("fair0", 8'hFF);
        chk("fair:first", 32'(gnt_idx), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step("fair", 8'hFF & ~(8'd1 << k));
            chk("fair:order", 32'(gnt_idx), 32'((k + 1) % 8));
            chk("fair:nobubble", 32'(gnt_valid), 32'd1);
        end

        // Wrap-around: after granting 5, index 0 wins before 5.
        do_reset();
        step("wrap5", 8'h20);
        chk("wrap:5", 32'(gnt_idx), 32'd5);
        step("wrap_idle", 8'h00);
        step("wrap0", 8'h21);
        chk("wrap:0first", 32'(gnt_idx), 32'd0);
        step("wrap5b", 8'h20);
        chk("wrap:5next", 32'(gnt_idx), 32'd5);

        // Timeout alternation with MAX_HOLD cycles each.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step("tout", 8'h03);
            chk("tout:alt", 32'(gnt_idx), 32'((i / MH) % 2));
        end
        // Lone requester keeps the grant past the limit.
        for (int i = 0; i < 12; i++) begin
            step("tout_lone", 8'h01);
            chk("tout_lone:gnt", 32'(gnt), 32'h01);
        end
        step("tout_sat", 8'h03);
        chk("tout_sat:handoff", 32'(gnt_idx), 32'd1);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        step("mid3", 8'h08);
        chk("mid:3", 32'(gnt_idx), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        m_owner = -1;
        m_ptr   = 0;
        m_owned = 0;
        chk("mid_rst:gnt", 32'(gnt), 32'h0);
        chk("mid_rst:valid", 32'(gnt_valid), 32'h0);
        req = 8'h00;
        #2;
        rst_n = 1'b1;
        step("mid_after", 8'h0A);
        chk("mid_after:idx1", 32'(gnt_idx), 32'd1);

        // Random traffic against the model.
        r = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 4))
                0: r = 8'($urandom);
                1: r = r & 8'($urandom);
                2: r = r | (8'd1 << $urandom_range(0, 7));
                3: r = r;
                default: r = (8'd1 << $urandom_range(0, 7));
            endcase
            if ($urandom_range(0, 31) == 0) r = 8'h00;
            step("rand", r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter MAX_HOLD, default 15: maximum consecutive grant cycles per owner before forced handoff; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  request lines; req[i] high = requester i wants the shared resource; level-sensitive.
REQ-005 gnt  output  8  one-hot grant, registered; all-zero when no owner.
REQ-006 gnt_idx  output  3  binary index of the current owner, registered; encoding identical to an 8x3 encoder of gnt.
REQ-007 gnt_valid  output  1  high iff gnt is non-zero, registered.

Function
REQ-008 The block SHALL implement two states: IDLE (no owner) and GRANT (one owner held in a 3-bit owner register).
REQ-009 IDLE -> GRANT on any edge where req != 0; the owner SHALL be selected by round-robin search starting at pointer ptr and wrapping 7 -> 0.
REQ-010 Grant latency SHALL be exactly one cycle: req sampled at edge N, gnt/gnt_idx/gnt_valid valid after edge N.
REQ-011 In GRANT, the grant SHALL be held while req[owner] stays high and the hold limit is not reached.
REQ-012 Release: on an edge where req[owner] is low, if other requests are pending the grant SHALL move directly to the next round-robin winner at that same edge (no idle bubble); otherwise the block SHALL go to IDLE with gnt = 0.
REQ-013 On every new grant to index k, ptr SHALL become (k+1) mod 8, so k has the lowest priority in the next search.
REQ-014 Hold counter: 4 bits minimum (sized to hold MAX_HOLD), cleared on every new grant, incremented each cycle the same owner is kept, saturating at MAX_HOLD.
REQ-015 Timeout: when MAX_HOLD != 0, the counter equals MAX_HOLD-1, req[owner] is still high and any other req bit is high, the grant SHALL move to the next round-robin winner at that edge, excluding the current owner.
REQ-016 If the timeout condition is reached with no other requester, the owner SHALL keep the grant and the counter SHALL saturate; handoff occurs on the first later edge where another request is seen.
REQ-017 Simultaneous release and timeout on the same edge SHALL be treated as a release (REQ-012).
REQ-018 gnt SHALL never have more than one bit set; gnt_idx SHALL equal the owner whenever gnt_valid is high and SHALL be 3'b000 when gnt_valid is low.
REQ-019 A requester SHALL NOT be granted on an edge where its req bit is low.
REQ-020 Requests rising during GRANT SHALL not disturb the current owner; they are only considered at release or timeout.

Reset
REQ-021 While rst_n is low: state = IDLE, ptr = 0, hold counter = 0, gnt = 8'h00, gnt_idx = 3'b000, gnt_valid = 0, applied immediately without waiting for clk.
REQ-022 Reset asserted mid-grant SHALL drop gnt asynchronously; after deassertion the first arbitration SHALL start from ptr = 0.
REQ-023 The first rising edge after rst_n deasserts SHALL be a normal arbitration edge.

Verification
REQ-024 Single request: req = 8'b0001_0000 after reset -> next cycle gnt = 8'b0001_0000, gnt_idx = 3'd4, gnt_valid = 1; req -> 0 -> gnt = 0 after next edge.
REQ-025 Fairness: req = 8'hFF held, each owner drops req for one cycle after being granted -> owners 0,1,2,...,7,0 in order with no idle cycle between grants.
REQ-026 Wrap-around: ptr = 6 (after granting 5), req = 8'b0010_0001 -> grant index 0 before index 5; after index 0 releases, index 5 is granted.
REQ-027 Timeout: MAX_HOLD = 4, req = 8'b0000_0011 held -> index 0 owns exactly 4 cycles, then index 1 owns 4 cycles, alternating; with req = 8'b0000_0001 only, index 0 keeps gnt indefinitely.
REQ-028 Reset mid-grant: owner 3 active, rst_n pulsed low between edges -> gnt = 0 and gnt_valid = 0 immediately; with req = 8'b0000_1010 after release, index 1 is granted first.
REQ-029 Every scenario SHALL check each cycle: $onehot0(gnt), gnt_valid == |gnt, and gnt_idx matches gnt encoding.
